// File: rtl/sequencer_decoder_pkg.sv
// Shared constants for the multi-cycle sequencer: opcodes, ALU op codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sequencer_decoder_pkg;

  // Instruction opcodes (OPC_W = 8 encoding); anything else executes as NOP
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_LDR = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_INC = 8'h05;
  localparam logic [7:0] OP_DEC = 8'h06;
  localparam logic [7:0] OP_CLR = 8'h07;
  localparam logic [7:0] OP_FIL = 8'h08;
  localparam logic [7:0] OP_JMP = 8'h09;
  localparam logic [7:0] OP_JZ  = 8'h0A;
  localparam logic [7:0] OP_JNZ = 8'h0B;
  localparam logic [7:0] OP_HLT = 8'h0C;

  // ALU operation codes; 0 is the idle value driven outside EXEC
  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_INC  = 5'd3;
  localparam logic [4:0] ALU_DEC  = 5'd4;

  // Controller states
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/sequencer_decoder_program_counter.sv
// Program counter: load has priority over increment, increment wraps at 2^PC_W.
// Latency: new value visible the cycle after inc/load.
// Backpressure: none; holds when neither inc nor load is asserted.
module sequencer_decoder_program_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_value,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // PC register: jump target wins, otherwise step by one with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_value;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/sequencer_decoder.sv
// Fetch/decode/execute/writeback controller driving ROM, GPR file and external ALU.
// Latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB); HLT parks in HALT.
// Backpressure: run low holds the FSM in FETCH; an instruction already started completes.
module sequencer_decoder
  import sequencer_decoder_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 8,
  parameter int OPC_W      = 8,
  parameter int ALU_OP_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  output logic [PC_W-1:0]           rom_addr,
  input  logic [OPC_W+2*DATA_W-1:0] rom_data,
  output logic                      gpr_w_enable,
  output logic [REG_ADDR_W-1:0]     gpr_w_addr,
  output logic [DATA_W-1:0]         gpr_w_data,
  output logic [REG_ADDR_W-1:0]     gpr_r_addr_a,
  output logic [REG_ADDR_W-1:0]     gpr_r_addr_b,
  input  logic [DATA_W-1:0]         gpr_r_data_a,
  input  logic [DATA_W-1:0]         gpr_r_data_b,
  output logic [ALU_OP_W-1:0]       alu_operation,
  output logic [DATA_W-1:0]         alu_A,
  output logic [DATA_W-1:0]         alu_B,
  input  logic [DATA_W-1:0]         alu_C,
  output logic                      zero_flag,
  output logic                      halted,
  output logic [PC_W-1:0]           pc
);

  localparam int INSTR_W = OPC_W + 2 * DATA_W;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [INSTR_W-1:0]    r_ir;
  logic                  r_z;
  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]     r_wdata;

  logic [OPC_W-1:0]      w_opc;
  logic [DATA_W-1:0]     w_arg_a;
  logic [DATA_W-1:0]     w_arg_b;
  logic                  w_is_write;
  logic                  w_use_a;
  logic                  w_use_b;
  logic                  w_use_alu;
  logic [ALU_OP_W-1:0]   w_alu_op;
  logic [DATA_W-1:0]     w_wdata;
  logic                  w_is_hlt;
  logic                  w_jump_taken;
  logic                  w_in_exec;
  logic                  w_in_wb;
  logic [PC_W-1:0]       w_pc;

  assign w_opc     = r_ir[2*DATA_W +: OPC_W];
  assign w_arg_a   = r_ir[DATA_W +: DATA_W];
  assign w_arg_b   = r_ir[0 +: DATA_W];
  assign w_in_exec = (r_state == EXEC);
  assign w_in_wb   = (r_state == WB);

  // Opcode decode: which operands are read, ALU op, and the value to be written back
  always_comb begin
    w_is_write = 1'b0;
    w_use_a    = 1'b0;
    w_use_b    = 1'b0;
    w_use_alu  = 1'b0;
    w_alu_op   = ALU_NONE;
    w_wdata    = '0;
    case (w_opc)
      OP_LD:  begin w_is_write = 1'b1; w_use_b = 1'b1; w_wdata = gpr_r_data_b; end
      OP_LDR: begin w_is_write = 1'b1; w_wdata = w_arg_b; end
      OP_ADD: begin w_is_write = 1'b1; w_use_a = 1'b1; w_use_b = 1'b1; w_use_alu = 1'b1;
                    w_alu_op = ALU_ADD; w_wdata = alu_C; end
      OP_SUB: begin w_is_write = 1'b1; w_use_a = 1'b1; w_use_b = 1'b1; w_use_alu = 1'b1;
                    w_alu_op = ALU_SUB; w_wdata = alu_C; end
      OP_INC: begin w_is_write = 1'b1; w_use_a = 1'b1; w_use_alu = 1'b1;
                    w_alu_op = ALU_INC; w_wdata = alu_C; end
      OP_DEC: begin w_is_write = 1'b1; w_use_a = 1'b1; w_use_alu = 1'b1;
                    w_alu_op = ALU_DEC; w_wdata = alu_C; end
      OP_CLR: begin w_is_write = 1'b1; w_wdata = '0; end
      OP_FIL: begin w_is_write = 1'b1; w_wdata = '1; end
      default: ;
    endcase
  end

  // Branch resolution uses the Z flag as it stands before this instruction's WB
  assign w_jump_taken = (w_opc == OP_JMP) ||
                        ((w_opc == OP_JZ)  &&  r_z) ||
                        ((w_opc == OP_JNZ) && !r_z);
  assign w_is_hlt     = (w_opc == OP_HLT);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:   if (run) w_state_nxt = DECODE;
      DECODE:  w_state_nxt = EXEC;
      EXEC:    w_state_nxt = WB;
      WB:      w_state_nxt = w_is_hlt ? HALT : FETCH;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // Instruction register: synchronous ROM output is valid during DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_ir <= '0;
    else if (r_state == DECODE) r_ir <= rom_data;
  end

  // Result register captured at the end of EXEC, consumed in WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_in_exec) begin
      r_wen   <= w_is_write;
      r_waddr <= w_arg_a[REG_ADDR_W-1:0];
      r_wdata <= w_wdata;
    end
  end

  // Z flag tracks the last value written to a GPR
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_z <= 1'b0;
    else if (w_in_wb && r_wen) r_z <= (r_wdata == '0);
  end

  sequencer_decoder_program_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_in_wb && !w_is_hlt && !w_jump_taken),
    .i_load       (w_in_wb && w_jump_taken),
    .i_load_value (w_arg_a[PC_W-1:0]),
    .o_pc         (w_pc)
  );

  assign pc            = w_pc;
  assign rom_addr      = w_pc;
  assign zero_flag     = r_z;
  assign halted        = (r_state == HALT);
  assign gpr_w_enable  = w_in_wb && r_wen;
  assign gpr_w_addr    = w_in_wb ? r_waddr : '0;
  assign gpr_w_data    = w_in_wb ? r_wdata : '0;
  assign gpr_r_addr_a  = (w_in_exec && w_use_a) ? w_arg_a[REG_ADDR_W-1:0] : '0;
  assign gpr_r_addr_b  = (w_in_exec && w_use_b) ? w_arg_b[REG_ADDR_W-1:0] : '0;
  assign alu_operation = (w_in_exec && w_use_alu) ? w_alu_op : '0;
  assign alu_A         = (w_in_exec && w_use_alu) ? gpr_r_data_a : '0;
  assign alu_B         = (w_in_exec && w_use_alu && w_use_b) ? gpr_r_data_b : '0;

endmodule

// File: tb/tb_sequencer_decoder.sv
// Directed bench for sequencer_decoder with behavioural ROM, GPR file and ALU.
// Latency: checks sampled on the falling edge, N negedges after reset/run release.
// Backpressure: exercises run low at reset release and run dropped mid-instruction.
module tb_sequencer_decoder;
  import sequencer_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic        gpr_w_enable;
  logic [2:0]  gpr_w_addr;
  logic [7:0]  gpr_w_data;
  logic [2:0]  gpr_r_addr_a;
  logic [2:0]  gpr_r_addr_b;
  logic [7:0]  gpr_r_data_a;
  logic [7:0]  gpr_r_data_b;
  logic [4:0]  alu_operation;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [7:0]  alu_C;
  logic        zero_flag;
  logic        halted;
  logic [7:0]  pc;

  logic [23:0] rom [256];
  logic [7:0]  gpr [8];
  int          wr_cnt = 0;
  int          wr_snap;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  sequencer_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .gpr_w_enable  (gpr_w_enable),
    .gpr_w_addr    (gpr_w_addr),
    .gpr_w_data    (gpr_w_data),
    .gpr_r_addr_a  (gpr_r_addr_a),
    .gpr_r_addr_b  (gpr_r_addr_b),
    .gpr_r_data_a  (gpr_r_data_a),
    .gpr_r_data_b  (gpr_r_data_b),
    .alu_operation (alu_operation),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_C         (alu_C),
    .zero_flag     (zero_flag),
    .halted        (halted),
    .pc            (pc)
  );

  // Synchronous ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // GPR file: combinational read, clocked write, write counter
  assign gpr_r_data_a = gpr[gpr_r_addr_a];
  assign gpr_r_data_b = gpr[gpr_r_addr_b];
  always @(posedge clk) begin
    if (gpr_w_enable) begin
      gpr[gpr_w_addr] <= gpr_w_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // External ALU
  always_comb begin
    alu_C = 8'h00;
    case (alu_operation)
      ALU_ADD: alu_C = alu_A + alu_B;
      ALU_SUB: alu_C = alu_A - alu_B;
      ALU_INC: alu_C = alu_A + 8'h01;
      ALU_DEC: alu_C = alu_A - 8'h01;
      default: alu_C = 8'h00;
    endcase
  end

  function automatic logic [23:0] ins(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
    return {o, a, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_NOP, 8'h00, 8'h00);
  endtask

  // Hold reset for two cycles, release on a falling edge with the given run level
  task automatic do_reset(input logic run_lvl);
    rst = 1'b1;
    run = run_lvl;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) gpr[i] = 8'h00;

    // ---- Test 1: LDR/LDR/ADD, CLR, undefined opcode, HLT at pc 5 ----
    clear_rom();
    rom[0] = ins(OP_LDR, 8'h01, 8'h05);
    rom[1] = ins(OP_LDR, 8'h02, 8'h03);
    rom[2] = ins(OP_ADD, 8'h01, 8'h02);
    rom[3] = ins(OP_CLR, 8'h04, 8'h00);
    rom[4] = ins(8'hEE,  8'h03, 8'h01);
    rom[5] = ins(OP_HLT, 8'h00, 8'h00);
    rst = 1'b1;
    run = 1'b1;
    cyc(2);
    chk("rst_pc", pc, 8'h00);
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_z", zero_flag, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_wen", gpr_w_enable, 1'b0);
    chk("rst_alu_op", alu_operation, 5'd0);
    wr_snap = wr_cnt;
    rst = 1'b0;
    cyc(2);
    chk("t1_no_wr_before_wb", gpr_w_enable, 1'b0);
    cyc(1);
    chk("t1_wb1_en", gpr_w_enable, 1'b1);
    chk("t1_wb1_addr", gpr_w_addr, 3'd1);
    chk("t1_wb1_data", gpr_w_data, 8'h05);
    cyc(4);
    chk("t1_wb2_en", gpr_w_enable, 1'b1);
    chk("t1_wb2_addr", gpr_w_addr, 3'd2);
    chk("t1_wb2_data", gpr_w_data, 8'h03);
    cyc(4);
    chk("t1_wb3_addr", gpr_w_addr, 3'd1);
    chk("t1_wb3_data", gpr_w_data, 8'h08);
    cyc(1);
    chk("t1_add_z", zero_flag, 1'b0);
    chk("t1_add_pc", pc, 8'h03);
    chk("t1_r1", gpr[1], 8'h08);
    cyc(4);
    chk("t1_clr_z", zero_flag, 1'b1);
    chk("t1_clr_pc", pc, 8'h04);
    cyc(3);
    chk("t1_undef_no_wr", gpr_w_enable, 1'b0);
    cyc(1);
    chk("t1_undef_pc", pc, 8'h05);
    chk("t1_undef_z", zero_flag, 1'b1);
    chk("t1_wr_count", wr_cnt - wr_snap, 4);
    cyc(3);
    chk("t1_hlt_wb_not_halted", halted, 1'b0);
    cyc(1);
    chk("t1_halted", halted, 1'b1);
    chk("t1_halt_pc", pc, 8'h05);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("t1_halt_rom_addr", rom_addr, 8'h05);
      chk("t1_halt_wen", gpr_w_enable, 1'b0);
    end
    chk("t1_halt_wr_count", wr_cnt - wr_snap, 4);
    chk("t1_still_halted", halted, 1'b1);

    // ---- Test 2: reset in EXEC of ADD ----
    clear_rom();
    rom[0] = ins(OP_LDR, 8'h01, 8'h05);
    rom[1] = ins(OP_CLR, 8'h02, 8'h00);
    rom[2] = ins(OP_ADD, 8'h01, 8'h01);
    do_reset(1'b1);
    chk("t2_reset_clears_halt", halted, 1'b0);
    cyc(10);
    chk("t2_exec_op", alu_operation, ALU_ADD);
    chk("t2_exec_A", alu_A, 8'h05);
    chk("t2_exec_B", alu_B, 8'h05);
    chk("t2_exec_raddr_a", gpr_r_addr_a, 3'd1);
    chk("t2_exec_z", zero_flag, 1'b1);
    wr_snap = wr_cnt;
    rst = 1'b1;
    #1;
    chk("t2_rst_op", alu_operation, 5'd0);
    chk("t2_rst_A", alu_A, 8'h00);
    chk("t2_rst_B", alu_B, 8'h00);
    chk("t2_rst_raddr_a", gpr_r_addr_a, 3'd0);
    chk("t2_rst_pc", pc, 8'h00);
    chk("t2_rst_z", zero_flag, 1'b0);
    chk("t2_rst_wen", gpr_w_enable, 1'b0);
    cyc(2);
    chk("t2_no_partial_write", wr_cnt - wr_snap, 0);
    chk("t2_r1_kept", gpr[1], 8'h05);
    rst = 1'b0;
    chk("t2_release_rom_addr", rom_addr, 8'h00);
    cyc(3);
    chk("t2_refetch_wb_data", gpr_w_data, 8'h05);
    chk("t2_refetch_wb_addr", gpr_w_addr, 3'd1);

    // ---- Test 3: DEC then JZ taken, then not taken followed by JNZ taken ----
    clear_rom();
    rom[0]    = ins(OP_LDR, 8'h03, 8'h01);
    rom[1]    = ins(OP_DEC, 8'h03, 8'h00);
    rom[2]    = ins(OP_JZ,  8'h10, 8'h00);
    rom[8'h10] = ins(OP_HLT, 8'h00, 8'h00);
    do_reset(1'b1);
    cyc(7);
    chk("t3_dec_data", gpr_w_data, 8'h00);
    cyc(5);
    chk("t3_jz_taken_pc", pc, 8'h10);
    chk("t3_jz_z", zero_flag, 1'b1);
    chk("t3_r3", gpr[3], 8'h00);
    rom[0]    = ins(OP_LDR, 8'h03, 8'h02);
    rom[3]    = ins(OP_JNZ, 8'h20, 8'h00);
    rom[8'h20] = ins(OP_HLT, 8'h00, 8'h00);
    do_reset(1'b1);
    cyc(12);
    chk("t3_jz_not_taken_pc", pc, 8'h03);
    chk("t3_nt_z", zero_flag, 1'b0);
    chk("t3_nt_r3", gpr[3], 8'h01);
    cyc(4);
    chk("t3_jnz_taken_pc", pc, 8'h20);
    cyc(8);
    chk("t3_jnz_halted", halted, 1'b1);

    // ---- Test 4: JMP 0xFF, INC wraps r0 and pc ----
    clear_rom();
    rom[0]    = ins(OP_FIL, 8'h00, 8'h00);
    rom[1]    = ins(OP_JMP, 8'hFF, 8'h00);
    rom[8'hFF] = ins(OP_INC, 8'h00, 8'h00);
    do_reset(1'b1);
    cyc(8);
    chk("t4_jmp_pc", pc, 8'hFF);
    chk("t4_fil_r0", gpr[0], 8'hFF);
    chk("t4_fil_z", zero_flag, 1'b0);
    cyc(3);
    chk("t4_inc_en", gpr_w_enable, 1'b1);
    chk("t4_inc_data", gpr_w_data, 8'h00);
    cyc(1);
    chk("t4_pc_wrap", pc, 8'h00);
    chk("t4_inc_z", zero_flag, 1'b1);
    chk("t4_r0", gpr[0], 8'h00);

    // ---- Test 5: run low at release, then run pulsed for one instruction ----
    clear_rom();
    rom[0] = ins(OP_LDR, 8'h05, 8'hAA);
    rom[1] = ins(OP_LDR, 8'h06, 8'hBB);
    do_reset(1'b0);
    wr_snap = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t5_stall_pc", pc, 8'h00);
      chk("t5_stall_wen", gpr_w_enable, 1'b0);
    end
    chk("t5_stall_no_wr", wr_cnt - wr_snap, 0);
    run = 1'b1;
    cyc(1);
    run = 1'b0;
    cyc(1);
    chk("t5_pre_wb_wen", gpr_w_enable, 1'b0);
    cyc(1);
    chk("t5_wb_en", gpr_w_enable, 1'b1);
    chk("t5_wb_addr", gpr_w_addr, 3'd5);
    chk("t5_wb_data", gpr_w_data, 8'hAA);
    cyc(1);
    chk("t5_pc_after", pc, 8'h01);
    cyc(8);
    chk("t5_stalled_pc", pc, 8'h01);
    chk("t5_single_write", wr_cnt - wr_snap, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
